mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port (mem + mmio decode downstream) between two requesters.
- Requester A is the CPU core's memory/fetch path. Requester B is a DMA/bootloader master, e.g. a UART loader writing program RAM.
- Fixed CPU priority with a starvation guard for DMA.
- Sits between core and memory; the core stalls on cpu_wait exactly as it does on mem_wait today.

Parameters:
ADDR_W, 16, address width (word address as presented to mem).
DATA_W, 16, data width.
STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending DMA request wins over the CPU.

Ports:
clk  input  1  clock.
rst_n  input  1  reset. Synchronous, active-low.
cpu_req  input  1  CPU access request. Held with stable fields until cpu_ack.
cpu_we  input  1  CPU write.
cpu_byte_en  input  1  CPU byte access.
cpu_byte_sel  input  1  CPU byte lane select.
cpu_addr  input  ADDR_W  CPU address.
cpu_wdata  input  DATA_W  CPU write data.
cpu_rdata  output  DATA_W  CPU read data, registered. Valid in the cpu_ack cycle and held afterwards.
cpu_ack  output  1  one-cycle completion pulse.
cpu_wait  output  1  cpu_req & ~cpu_ack (combinational).
dma_req  input  1  DMA request. Same holding rule as cpu_req.
dma_we  input  1  DMA write. DMA accesses are always full word.
dma_addr  input  ADDR_W  DMA address.
dma_wdata  input  DATA_W  DMA write data.
dma_rdata  output  DATA_W  DMA read data, registered.
dma_ack  output  1  one-cycle completion pulse.
mem_en  output  1  memory access strobe.
mem_we  output  1  memory write enable.
mem_byte_en  output  1  memory byte access.
mem_byte_sel  output  1  memory byte lane.
mem_addr  output  ADDR_W  memory address.
mem_wdata  output  DATA_W  memory write data.
mem_rdata  input  DATA_W  memory read data. Valid the cycle after issue when mem_wait=0.
mem_wait  input  1  memory/mmio stall.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. Registered owner bit (CPU/DMA). Registered latched request fields.
- Reset (rst_n=0 at posedge):
  - state=IDLE; owner=CPU; starve counter=0.
  - All outputs 0: mem_*, cpu_ack, dma_ack, cpu_rdata, dma_rdata.
  - An in-flight access is abandoned and no ack is produced.
- IDLE, arbitration (evaluated every IDLE cycle):
  - CPU wins if cpu_req and (~dma_req or starve < STARVE_LIMIT); otherwise DMA wins if dma_req.
  - On a win: latch the winner's addr/we/wdata/byte fields (DMA byte_en=0, byte_sel=0), set owner, go to ISSUE.
  - No request: stay in IDLE, mem_en=0.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, on each grant to the CPU while dma_req=1.
  - Clears on any grant to DMA.
  - Unchanged otherwise.
- ISSUE: mem_en=1; mem_* driven from the latched fields. Next state is WAIT.
- WAIT:
  - mem_wait=1: stay; mem_en=1 and fields held stable.
  - mem_wait=0: access complete. Capture mem_rdata into the owner's rdata register; writes leave rdata unchanged. Pulse the owner's ack for exactly one cycle (the cycle after the WAIT exit edge). Return to IDLE.
- Latency:
  - Request seen in IDLE to ack = 3 cycles minimum (IDLE → ISSUE → WAIT → ack with next IDLE).
  - Each mem_wait cycle adds one cycle.
  - Back-to-back access from the same requester: 3-cycle throughput. The ack cycle is itself an IDLE cycle, so the requester must drop or update req in that cycle. A req still high during ack is treated as a new request.
- Request dropped before grant: nothing issued. Dropped after grant: the access completes and ack still pulses.
- Only one ack is asserted per cycle. cpu_ack and dma_ack are never both 1.
- mem_en is 0 in IDLE. mem_* outputs hold their last values when idle, except mem_en and mem_we, which are 0 in IDLE.

Test Plan:
- CPU read alone: cpu_req=1, addr=0x0010, memory returns 0xBEEF, mem_wait=0 → mem_en high 2 cycles; cpu_ack at cycle 3; cpu_rdata=0xBEEF; cpu_wait=1 in cycles 0-2.
- DMA write alone: dma_req, addr=0x0100, wdata=0x1234 → mem_we=1 with mem_addr=0x0100 and mem_byte_en=0; dma_ack at cycle 3; dma_rdata unchanged.
- Contention: cpu_req and dma_req held continuously (CPU re-requests every IDLE), STARVE_LIMIT=4 → grant order CPU,CPU,CPU,CPU,DMA,CPU…; counter returns to 0 after the DMA grant.
- mem_wait stretch: CPU read with mem_wait=1 for 3 cycles in WAIT → mem_en and fields stable throughout; cpu_ack at cycle 6; rdata captured after mem_wait falls.
- CPU byte write: byte_en=1, byte_sel=1, addr=0x0020, wdata=0x00AB → mem_byte_en=1, mem_byte_sel=1, mem_addr=0x0020, mem_wdata=0x00AB; cpu_ack at cycle 3.
- Reset mid-access: rst_n=0 during WAIT with DMA owner → next cycle IDLE; mem_en=0; no dma_ack; starve=0; the next cpu_req is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single downstream memory port (RAM plus MMIO decode) between the
// CPU core's memory/fetch path and a DMA/bootloader master such as the UART
// program loader. The CPU has fixed priority. A starvation counter lets a
// pending DMA request win once the CPU has taken STARVE_LIMIT consecutive
// grants while DMA was waiting. The core stalls on cpu_wait_o in the same way
// it stalls on mem_wait today.
//
// Every access takes the path IDLE -> ISSUE -> WAIT -> (ack, back in IDLE).
// That gives a minimum of 3 cycles from request to ack. Each mem_wait_i cycle
// in WAIT adds one cycle.
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   cpu_req_i            CPU request, held with stable fields until cpu_ack_o
//   cpu_we_i             CPU write
//   cpu_byte_en_i        CPU byte access
//   cpu_byte_sel_i       CPU byte lane select
//   cpu_addr_i           CPU word address
//   cpu_wdata_i          CPU write data
//   cpu_rdata_o          CPU read data (registered; valid in the ack cycle and held)
//   cpu_ack_o            one-cycle CPU completion pulse
//   cpu_wait_o           cpu_req_i & ~cpu_ack_o
//   dma_req_i            DMA request, same holding rule as the CPU
//   dma_we_i             DMA write (DMA accesses are always full word)
//   dma_addr_i           DMA word address
//   dma_wdata_i          DMA write data
//   dma_rdata_o          DMA read data (registered)
//   dma_ack_o            one-cycle DMA completion pulse
//   mem_en_o             memory access strobe (ISSUE and WAIT)
//   mem_we_o             memory write enable (0 in IDLE)
//   mem_byte_en_o        memory byte access
//   mem_byte_sel_o       memory byte lane
//   mem_addr_o           memory address
//   mem_wdata_o          memory write data
//   mem_rdata_i          memory read data, valid in WAIT when mem_wait_i = 0
//   mem_wait_i           memory/MMIO stall
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic              cpu_byte_en_i,
    input  logic              cpu_byte_sel_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_wait_o,

    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_ack_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic              mem_byte_en_o,
    output logic              mem_byte_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_wait_i
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic                ownerDma_q,  ownerDma_d;
    logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;
    logic                we_q,        we_d;
    logic                byteEn_q,    byteEn_d;
    logic                byteSel_q,   byteSel_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [DATA_W-1:0]   cpuRdata_q,  cpuRdata_d;
    logic [DATA_W-1:0]   dmaRdata_q,  dmaRdata_d;
    logic                cpuAck_q,    cpuAck_d;
    logic                dmaAck_q,    dmaAck_d;
    logic                grantCpu;
    logic                grantDma;

    // Arbitration and the access sequence.
    // IDLE picks a winner every cycle, including the ack cycle itself, so a
    // request that is still high during its ack is taken as a fresh request.
    // The CPU normally wins. Once DMA has lost STARVE_LIMIT arbitrations in a
    // row, a waiting DMA request gets through. The winner's fields are copied
    // into the latch registers so the memory bus stays stable through ISSUE
    // and WAIT, even if the requester drops its request after the grant.
    // DMA accesses are always full word, so the byte controls are forced low
    // for a DMA grant.
    always_comb begin
        state_d     = state_q;
        ownerDma_d  = ownerDma_q;
        starveCnt_d = starveCnt_q;
        we_d        = we_q;
        byteEn_d    = byteEn_q;
        byteSel_d   = byteSel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpuRdata_d  = cpuRdata_q;
        dmaRdata_d  = dmaRdata_q;
        cpuAck_d    = 1'b0;
        dmaAck_d    = 1'b0;
        grantCpu    = 1'b0;
        grantDma    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_i && (!dma_req_i || (starveCnt_q < STARVE_MAX))) begin
                    grantCpu = 1'b1;
                end else if (dma_req_i) begin
                    grantDma = 1'b1;
                end

                if (grantCpu) begin
                    state_d    = ISSUE;
                    ownerDma_d = 1'b0;
                    we_d       = cpu_we_i;
                    byteEn_d   = cpu_byte_en_i;
                    byteSel_d  = cpu_byte_sel_i;
                    addr_d     = cpu_addr_i;
                    wdata_d    = cpu_wdata_i;
                    if (dma_req_i && (starveCnt_q != STARVE_MAX)) begin
                        starveCnt_d = starveCnt_q + STARVE_W'(1);
                    end
                end else if (grantDma) begin
                    state_d     = ISSUE;
                    ownerDma_d  = 1'b1;
                    we_d        = dma_we_i;
                    byteEn_d    = 1'b0;
                    byteSel_d   = 1'b0;
                    addr_d      = dma_addr_i;
                    wdata_d     = dma_wdata_i;
                    starveCnt_d = '0;
                end
            end

            ISSUE: begin
                state_d = WAIT;
            end

            WAIT: begin
                if (!mem_wait_i) begin
                    state_d = IDLE;
                    if (ownerDma_q) begin
                        dmaAck_d = 1'b1;
                        if (!we_q) begin
                            dmaRdata_d = mem_rdata_i;
                        end
                    end else begin
                        cpuAck_d = 1'b1;
                        if (!we_q) begin
                            cpuRdata_d = mem_rdata_i;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers.
    // Reset is synchronous. It abandons any access in flight without an ack,
    // and it clears the captured read data and the latched bus fields, so
    // every output reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ownerDma_q  <= 1'b0;
            starveCnt_q <= '0;
            we_q        <= 1'b0;
            byteEn_q    <= 1'b0;
            byteSel_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpuRdata_q  <= '0;
            dmaRdata_q  <= '0;
            cpuAck_q    <= 1'b0;
            dmaAck_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ownerDma_q  <= ownerDma_d;
            starveCnt_q <= starveCnt_d;
            we_q        <= we_d;
            byteEn_q    <= byteEn_d;
            byteSel_q   <= byteSel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpuRdata_q  <= cpuRdata_d;
            dmaRdata_q  <= dmaRdata_d;
            cpuAck_q    <= cpuAck_d;
            dmaAck_q    <= dmaAck_d;
        end
    end

    // Output mapping.
    // The strobe and write enable are gated by state, so they drop to 0 in
    // IDLE. The address, data and byte fields keep their last values between
    // accesses.
    assign mem_en_o       = (state_q != IDLE);
    assign mem_we_o       = (state_q != IDLE) & we_q;
    assign mem_byte_en_o  = byteEn_q;
    assign mem_byte_sel_o = byteSel_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;

    assign cpu_rdata_o = cpuRdata_q;
    assign dma_rdata_o = dmaRdata_q;
    assign cpu_ack_o   = cpuAck_q;
    assign dma_ack_o   = dmaAck_q;
    assign cpu_wait_o  = cpu_req_i & ~cpuAck_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter.
// - A table of single accesses is applied one entry at a time. When a request
//   is driven, its expected completion is pushed to a scoreboard queue. The
//   entry is popped and compared when an ack appears.
// - Hand-written sequences cover reset, CPU/DMA contention (the starvation
//   guard) and a reset that lands in the middle of an access.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, cpu_byte_en, cpu_byte_sel;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ack, cpu_wait;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          dma_ack;
    logic          mem_en, mem_we, mem_byte_en, mem_byte_sel;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_wait;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_i      (cpu_req),
        .cpu_we_i       (cpu_we),
        .cpu_byte_en_i  (cpu_byte_en),
        .cpu_byte_sel_i (cpu_byte_sel),
        .cpu_addr_i     (cpu_addr),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_rdata_o    (cpu_rdata),
        .cpu_ack_o      (cpu_ack),
        .cpu_wait_o     (cpu_wait),
        .dma_req_i      (dma_req),
        .dma_we_i       (dma_we),
        .dma_addr_i     (dma_addr),
        .dma_wdata_i    (dma_wdata),
        .dma_rdata_o    (dma_rdata),
        .dma_ack_o      (dma_ack),
        .mem_en_o       (mem_en),
        .mem_we_o       (mem_we),
        .mem_byte_en_o  (mem_byte_en),
        .mem_byte_sel_o (mem_byte_sel),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .mem_wait_i     (mem_wait)
    );

    typedef struct {
        logic          isDma;
        logic          we;
        logic          byteEn;
        logic          byteSel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] memData;
        int            waitCycles;
        int            expAckCycle;
        logic          expByteEn;
        logic          expByteSel;
        logic [DW-1:0] expCpuRdata;
        logic [DW-1:0] expDmaRdata;
    } vec_t;

    typedef struct {
        logic          isDma;
        int            ackCycle;
        logic [DW-1:0] cpuRdata;
        logic [DW-1:0] dmaRdata;
    } exp_t;

    exp_t sbQueue[$];
    vec_t vecs[6];
    vec_t postVec;
    int   errors = 0;
    int   checks = 0;

    // Compares one observed value against the value the bench expects.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Records a timeout as a failed comparison.
    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: no ack within the cycle budget", name);
    endtask

    task automatic dropRequests();
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    // Drives one requester with the fields of a table entry.
    task automatic applyStimulus(input vec_t v);
        if (v.isDma) begin
            dma_req   = 1'b1;
            dma_we    = v.we;
            dma_addr  = v.addr;
            dma_wdata = v.wdata;
        end else begin
            cpu_req      = 1'b1;
            cpu_we       = v.we;
            cpu_byte_en  = v.byteEn;
            cpu_byte_sel = v.byteSel;
            cpu_addr     = v.addr;
            cpu_wdata    = v.wdata;
        end
        mem_wait  = 1'b0;
        mem_rdata = ~v.memData;
    endtask

    // Runs one access from request to ack while acting as the memory.
    // Cycle 0 is the IDLE cycle in which the request is first seen.
    task automatic runTxn(input vec_t v, input string tag);
        exp_t e;
        logic acked = 1'b0;
        @(negedge clk);
        applyStimulus(v);
        e.isDma    = v.isDma;
        e.ackCycle = v.expAckCycle;
        e.cpuRdata = v.expCpuRdata;
        e.dmaRdata = v.expDmaRdata;
        sbQueue.push_back(e);
        #1;
        checkOutput({tag, ".wait0"}, {31'd0, cpu_wait}, {31'd0, ~v.isDma});
        checkOutput({tag, ".en0"}, {31'd0, mem_en}, 32'd0);
        for (int cyc = 1; cyc <= v.waitCycles + 8 && !acked; cyc++) begin
            @(posedge clk);
            #1;
            mem_wait  = (cyc >= 2) && (cyc < 2 + v.waitCycles);
            mem_rdata = (cyc == 2 + v.waitCycles) ? v.memData : ~v.memData;
            if (cpu_ack || dma_ack) begin
                acked = 1'b1;
                e = sbQueue.pop_front();
                checkOutput({tag, ".owner"}, {30'd0, cpu_ack, dma_ack},
                            e.isDma ? 32'd1 : 32'd2);
                checkOutput({tag, ".latency"}, cyc, e.ackCycle);
                checkOutput({tag, ".cpuRdata"}, {16'd0, cpu_rdata}, {16'd0, e.cpuRdata});
                checkOutput({tag, ".dmaRdata"}, {16'd0, dma_rdata}, {16'd0, e.dmaRdata});
                checkOutput({tag, ".idleEn"}, {30'd0, mem_en, mem_we}, 32'd0);
                checkOutput({tag, ".waitAck"}, {31'd0, cpu_wait}, 32'd0);
                dropRequests();
            end else if (cyc <= 2 + v.waitCycles) begin
                checkOutput({tag, ".bus"},
                            {12'd0, mem_en, mem_we, mem_byte_en, mem_byte_sel, mem_addr},
                            {12'd0, 1'b1, v.we, v.expByteEn, v.expByteSel, v.addr});
                checkOutput({tag, ".wdata"}, {16'd0, mem_wdata}, {16'd0, v.wdata});
                checkOutput({tag, ".wait"}, {31'd0, cpu_wait}, {31'd0, ~v.isDma});
            end
        end
        if (!acked) begin
            timeoutFail({tag, ".ack"});
            if (sbQueue.size() > 0) void'(sbQueue.pop_front());
            dropRequests();
        end else begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".pulse"}, {30'd0, cpu_ack, dma_ack}, 32'd0);
        end
    endtask

    // Holds both requests high and checks the grant order against a small
    // starvation model. The model assumes the counter is 0 on entry.
    task automatic runContention(input int nGrants, input string tag);
        logic order[$];
        logic expDma;
        int   sm     = 0;
        int   grants = 0;
        for (int i = 0; i < nGrants; i++) begin
            if (sm < LIMIT) begin
                order.push_back(1'b0);
                sm = sm + 1;
            end else begin
                order.push_back(1'b1);
                sm = 0;
            end
        end
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte_en = 1'b0; cpu_byte_sel = 1'b0;
        cpu_addr = 16'h0A00; cpu_wdata = 16'h0000;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0B00; dma_wdata = 16'h0000;
        mem_wait = 1'b0; mem_rdata = 16'h1357;
        for (int cyc = 1; cyc <= nGrants * 3 + 10 && grants < nGrants; cyc++) begin
            @(posedge clk);
            #1;
            if (cpu_ack || dma_ack) begin
                expDma = order.pop_front();
                checkOutput($sformatf("%s.grant%0d", tag, grants), {30'd0, cpu_ack, dma_ack},
                            expDma ? 32'd1 : 32'd2);
                checkOutput($sformatf("%s.slot%0d", tag, grants), cyc, 3 * (grants + 1));
                grants++;
                if (grants == nGrants) dropRequests();
            end
        end
        if (grants < nGrants) begin
            timeoutFail({tag, ".grants"});
            dropRequests();
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".quiet"}, {30'd0, mem_en, cpu_ack | dma_ack}, 32'd0);
    endtask

    // Main sequence: reset, the access table, contention, then a reset in the
    // middle of a DMA access.
    initial begin
        //            dma  we   be   bs   addr      wdata     memData  w  ack  expBe expBs cpuRd     dmaRd
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, 3, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h1234, 16'hDEAD, 0, 3, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 3, 6, 1'b0, 1'b0, 16'h5A5A, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h00AB, 16'h4321, 0, 3, 1'b1, 1'b1, 16'h5A5A, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hC0DE, 1, 4, 1'b0, 1'b0, 16'h5A5A, 16'hC0DE};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'hFFFF, 16'h9999, 2, 5, 1'b0, 1'b0, 16'h5A5A, 16'hC0DE};
        postVec = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'h7777, 0, 3, 1'b0, 1'b0, 16'h7777, 16'h0000};

        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte_en = 1'b0; cpu_byte_sel = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_wait = 1'b0; mem_rdata = 16'hFFFF;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.bus", {12'd0, mem_en, mem_we, mem_byte_en, mem_byte_sel, mem_addr}, 32'd0);
        checkOutput("rst.wdata", {16'd0, mem_wdata}, 32'd0);
        checkOutput("rst.acks", {30'd0, cpu_ack, dma_ack}, 32'd0);
        checkOutput("rst.rdata", {cpu_rdata, dma_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle.noReq", {29'd0, mem_en, cpu_ack, dma_ack}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            runTxn(vecs[i], $sformatf("vec%0d", i));
        end

        runContention(10, "contend");

        $display("[TB] reset during a DMA access");
        @(negedge clk);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0400; dma_wdata = 16'h0000;
        mem_wait = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mid.preEn", {31'd0, mem_en}, 32'd1);
        rst_n = 1'b0;
        dma_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid.en", {30'd0, mem_en, mem_we}, 32'd0);
        checkOutput("mid.acks", {30'd0, cpu_ack, dma_ack}, 32'd0);
        checkOutput("mid.rdata", {cpu_rdata, dma_rdata}, 32'd0);
        checkOutput("mid.addr", {16'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;
        mem_wait = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("mid.quiet%0d", i), {29'd0, mem_en, cpu_ack, dma_ack}, 32'd0);
        end

        runTxn(postVec, "post");
        runContention(5, "postContend");

        if (sbQueue.size() != 0) begin
            timeoutFail("scoreboard.leftover");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Stops a run that somehow stalls inside a task.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
